// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha2_pkg
//  Brief    : Shared SHA-2 message-schedule constants and FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sha2_pkg;

    localparam int SHA256_WIDTH  = 32;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA256_S0_R1  = 7;
    localparam int SHA256_S0_R2  = 18;
    localparam int SHA256_S0_SH  = 3;
    localparam int SHA256_S1_R1  = 17;
    localparam int SHA256_S1_R2  = 19;
    localparam int SHA256_S1_SH  = 10;

    localparam int SHA512_WIDTH  = 64;
    localparam int SHA512_ROUNDS = 80;
    localparam int SHA512_S0_R1  = 1;
    localparam int SHA512_S0_R2  = 8;
    localparam int SHA512_S0_SH  = 7;
    localparam int SHA512_S1_R1  = 19;
    localparam int SHA512_S1_R2  = 61;
    localparam int SHA512_S1_SH  = 6;

    localparam int BLOCK_WORDS = 16;
    localparam int INDEX_W     = 8;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sha2_msg_schedule_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha2_msg_schedule_if
//  Brief    : Input message stream and output schedule stream bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface sha2_msg_schedule_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_index;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sha2_msg_schedule_small_sigma.sv
`default_nettype none
// ============================================================================
//  Module   : small_sigma
//  Brief    : Generalised SHA-2 small sigma: rotr(x,R1) ^ rotr(x,R2) ^ (x >> SH).
//  Revision : 1.0 - initial release
// ============================================================================
module small_sigma #(
    parameter int WIDTH = 32,
    parameter int R1    = 7,
    parameter int R2    = 18,
    parameter int SH    = 3
) (
    input  wire logic [WIDTH-1:0] x_i,
    output logic      [WIDTH-1:0] y_o
);
    localparam int R1M = R1 % WIDTH;
    localparam int R2M = R2 % WIDTH;

    logic [WIDTH-1:0] w_rot1;
    logic [WIDTH-1:0] w_rot2;
    logic [WIDTH-1:0] w_shr;

    // A zero rotate makes the left shift vanish, leaving x unchanged.
    assign w_rot1 = (x_i >> R1M) | (x_i << (WIDTH - R1M));
    assign w_rot2 = (x_i >> R2M) | (x_i << (WIDTH - R2M));
    assign w_shr  = x_i >> SH;
    assign y_o    = w_rot1 ^ w_rot2 ^ w_shr;
endmodule
`default_nettype wire

// File: rtl/sha2_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : sha2_msg_schedule
//  Brief    : Loads a 16-word block, then streams the expanded schedule W[t].
//  Revision : 1.0 - initial release
// ============================================================================
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int WIDTH  = SHA256_WIDTH,
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int S0_R1  = SHA256_S0_R1,
    parameter int S0_R2  = SHA256_S0_R2,
    parameter int S0_SH  = SHA256_S0_SH,
    parameter int S1_R1  = SHA256_S1_R1,
    parameter int S1_R2  = SHA256_S1_R2,
    parameter int S1_SH  = SHA256_S1_SH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sha2_msg_schedule_if.slave    bus
);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ROUNDS - 1);
    localparam logic [INDEX_W-1:0] FIRST_EXP = INDEX_W'(BLOCK_WORDS);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [INDEX_W-1:0] t_q, t_d;
    logic [WIDTH-1:0]   buf_q [BLOCK_WORDS];

    logic [3:0]       w_slot;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_last;
    logic [WIDTH-1:0] w_sig0;
    logic [WIDTH-1:0] w_sig1;
    logic [WIDTH-1:0] w_expand;
    logic [WIDTH-1:0] w_out_data;

    assign w_slot     = t_q[3:0];
    assign w_in_fire  = bus.in_valid  && (state_q == LOAD);
    assign w_out_fire = bus.out_ready && (state_q == EMIT);
    assign w_last     = (state_q == EMIT) && (t_q == LAST_IDX);

    // Slot t%16 still holds W[t-16]; the other taps are fixed offsets mod 16.
    small_sigma #(.WIDTH(WIDTH), .R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_sigma0 (
        .x_i (buf_q[w_slot + 4'd1]),
        .y_o (w_sig0)
    );

    small_sigma #(.WIDTH(WIDTH), .R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_sigma1 (
        .x_i (buf_q[w_slot - 4'd2]),
        .y_o (w_sig1)
    );

    assign w_expand   = w_sig1 + buf_q[w_slot - 4'd7] + w_sig0 + buf_q[w_slot];
    assign w_out_data = (t_q < FIRST_EXP) ? buf_q[w_slot] : w_expand;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        case (state_q)
            LOAD: begin
                if (w_in_fire) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = EMIT;
                        t_d     = '0;
                    end
                end
            end
            EMIT: begin
                if (w_out_fire) begin
                    if (w_last) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    // Buffer is deliberately unreset; a new block always refills every slot.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            buf_q[cnt_q] <= bus.in_data;
        end else if (w_out_fire) begin
            buf_q[w_slot] <= w_out_data;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_index = t_q;
    assign bus.out_last  = w_last;
    assign bus.out_data  = w_out_data;
endmodule
`default_nettype wire

// File: doc/sha2_msg_schedule.md
# sha2_msg_schedule

Parametrised SHA-2 message-schedule expander. It accepts one 16-word message block over a valid/ready input stream, then emits the full schedule W[0..ROUNDS-1], one word per handshake, to the compression round datapath. The expansion uses two instances of a generalised small-sigma function (rotr ^ rotr ^ shr) with configurable amounts. A single block therefore serves SHA-256 (default) and SHA-512 (WIDTH=64, ROUNDS=80, sigma0 1/8/7, sigma1 19/61/6).

## Interface
- WIDTH, 32: word width in bits.
- ROUNDS, 64: schedule length; legal range 16..255.
- S0_R1, 7 / S0_R2, 18 / S0_SH, 3: sigma0 rotate, rotate and shift amounts.
- S1_R1, 17 / S1_R2, 19 / S1_SH, 10: sigma1 rotate, rotate and shift amounts.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a message word.
- in_ready  out  1  high in LOAD only.
- in_data  in  WIDTH  message word; words arrive in order W[0] first.
- out_valid  out  1  high in EMIT only.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  W[out_index].
- out_index  out  8  schedule index t, 0..ROUNDS-1.
- out_last  out  1  out_valid && out_index==ROUNDS-1.

## Operation
- State machine with two states, LOAD and EMIT.
  - LOAD: in_ready=1. Each in_valid&&in_ready beat writes buf[cnt] and increments cnt. On the 16th beat (cnt==15), go to EMIT with t=0.
  - EMIT: in_ready=0; in_valid is ignored.
- 16-entry circular word buffer buf[0..15], indexed by t mod 16 (the low 4 bits of t).
- Output word for t<16: out_data = buf[t].
- Output word for t>=16: out_data = sigma1(buf[(t-2)%16]) + buf[(t-7)%16] + sigma0(buf[(t-15)%16]) + buf[(t-16)%16], sum mod 2^WIDTH with carries discarded.
  - On that word's handshake, write out_data into buf[t%16]. This slot held W[t-16], which is no longer needed.
- sigma(x) = rotr(x,R1) ^ rotr(x,R2) ^ (x >> SH), where the shift is logical. Rotate amounts are taken mod WIDTH.
- Each out_valid&&out_ready handshake increments t.
- The handshake with out_last=1 returns the machine to LOAD with cnt=0. A new block may then start immediately.
- Reset values: state=LOAD, cnt=0, t=0, in_ready=1, out_valid=0, out_index=0, out_last=0. buf is not reset, and out_data is don't-care while out_valid=0.
- Reset asserted mid-LOAD or mid-EMIT aborts the block. The next cycle shows the reset values, and partial data is discarded.
- ROUNDS=16 degenerates to pass-through: the expansion path is never selected.

## Timing
- in_ready, out_valid, out_last and out_index are decoded from registered state only, with no combinational path from in_valid or out_ready.
- out_data is combinational from buf and t: two sigma stages plus a 4-input adder, within one cycle.
- Latency: out_valid rises the cycle after the 16th input beat.
- Throughput: one word per cycle while out_ready=1. A block occupies 16 + ROUNDS cycles minimum, since LOAD and EMIT do not overlap.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable and buf is unchanged.

## Structure
- Shared package sha2_pkg holds:
  - the SHA-256 and SHA-512 parameter constants (widths, ROUNDS, sigma amounts);
  - the state enum {LOAD, EMIT}.
- Sub-module small_sigma, parameters WIDTH, R1, R2, SH: purely combinational, instantiated twice (sigma0 and sigma1).
- Top level contains the FSM, the cnt/t counters, buf, the adder and the handshake logic.

## Test plan
- "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Required: W0..W15 echoed, W16=0x61626380, W17=0x000F0000, out_last at index 63.
  - All 64 words match a software model.
- Backpressure: hold out_ready low for 5 cycles at t=20 → out_data and out_index=20 stay constant. Resume → W21 follows without loss or duplication.
- Input stalls: in_valid toggled randomly during LOAD → 16 words captured in order. out_valid rises exactly one cycle after the 16th beat. in_valid held high during EMIT has no effect.
- Reset mid-EMIT at t=40 → next cycle in_ready=1, out_valid=0, out_index=0. A fresh block then yields the correct W0..W63.
- Back-to-back blocks: the second block starts on the cycle after the first block's out_last handshake. Both schedules match the model.
- SHA-512 parameter set (64/80, 1/8/7, 19/61/6) with the "abc" block → all 80 words match the model, and out_last at index 79.
